// File: rtl/riscv_isa_pkg.sv
// Shared ISA-level types for the fetch front end: instruction word, fetch packet and fetch FSM states.
// Consumers: fetch_queue (top) and anything that decodes its output packet.
package riscv_isa;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN         = 32;

  typedef logic [ILEN-1:0] INSTRUCTION;

  // Layout of the decode-facing packet at the default address width; pc sits in the upper bits.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    INSTRUCTION              instr;
  } FETCH_PACKET;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FULL = 2'd2
  } FETCH_STATE;

  // A cycle is a stall when fetch waits on the icache or is blocked by a full queue.
  function automatic logic fetch_stalled(input FETCH_STATE state, input logic cache_valid);
    return ((state == REQ) && !cache_valid) || (state == FULL);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered circular buffer with synchronous flush and occupancy count; head is readable without a pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
#(
  parameter int  DEPTH = 4,
  parameter type T     = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  T                           push_data,
  input  logic                       pop,
  output T                           pop_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T                mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC generator, icache request port and instruction queue toward decode.
// Define FETCH_QUEUE_PERF_EN to add the stall-cycle and flush counters.
module fetch_queue
  import riscv_isa::*;
#(
  parameter int              XLEN        = 32,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 jump,
  input  logic [XLEN-1:0]                      jump_addr,
  output logic [XLEN-1:0]                      cache_instruction_addr,
  input  logic [31:0]                          cache_instruction_data,
  input  logic                                 cache_instruction_valid,
  output logic [XLEN+31:0]                     decode_instruction_data,
  output logic                                 decode_instruction_valid,
  input  logic                                 decode_ready,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]     queue_count
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0]                          perf_stall_cycles,
  output logic [31:0]                          perf_flush_count
`endif
);

  localparam int CW = $clog2(QUEUE_DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    INSTRUCTION      instr;
  } fetch_packet_t;

  FETCH_STATE      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push;
  logic            pop;
  logic            flush;
  logic            q_empty;
  logic [CW:0]     occ_after_push;
  fetch_packet_t   push_pkt;
  fetch_packet_t   head_pkt;
  logic            unused_jump_lsbs;

  assign pop            = decode_instruction_valid && decode_ready;
  assign occ_after_push = {1'b0, queue_count} + (CW+1)'(1) - (CW+1)'(pop);
  assign push_pkt       = '{pc: pc_q, instr: cache_instruction_data};
  assign unused_jump_lsbs = ^jump_addr[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (jump) begin
      // Redirect wins over everything: same-cycle response is dropped, queue emptied.
      flush   = 1'b1;
      pc_d    = {jump_addr[XLEN-1:2], 2'b00};
      state_d = REQ;
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (cache_instruction_valid) begin
            push = 1'b1;
            pc_d = pc_q + XLEN'(4);
            if (occ_after_push == (CW+1)'(QUEUE_DEPTH)) state_d = FULL;
          end
        end
        FULL: begin
          if (pop) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .T     (fetch_packet_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (push_pkt),
    .pop       (pop),
    .pop_data  (head_pkt),
    .empty     (q_empty),
    .count     (queue_count)
  );

  assign cache_instruction_addr   = pc_q;
  assign decode_instruction_data  = head_pkt;
  assign decode_instruction_valid = !q_empty;

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (fetch_stalled(state_q, cache_instruction_valid) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (jump && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_count  = flush_cnt_q;
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised next-generation instruction fetch stage: PC generator, icache request interface and a QUEUE_DEPTH-entry instruction buffer feeding decode through a valid/ready handshake.
- Decouples icache latency from decode back-pressure.
- Redirects on jump and flushes all buffered and in-flight work.
- Sits between icache and decode.

Parameters:
XLEN, 32, PC/address width
QUEUE_DEPTH, 4, buffer entries; power of two, >=2
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
jump  in  1  redirect request, single-cycle pulse
jump_addr  in  XLEN  redirect target
cache_instruction_addr  out  XLEN  fetch address to icache
cache_instruction_data  in  32  instruction word from icache
cache_instruction_valid  in  1  data valid for the address driven this cycle
decode_instruction_data  out  FETCH_PACKET  {pc, instr} at queue head
decode_instruction_valid  out  1  queue non-empty
decode_ready  in  1  decode accepts head this cycle
queue_count  out  $clog2(QUEUE_DEPTH+1)  occupied entries

Behaviour:
- Clock and reset: one clock (clk). Reset (port reset) is synchronous and active-low.
- Reset values (reset=0 at posedge):
  - pc = RESET_PC.
  - Queue empty; queue_count = 0; decode_instruction_valid = 0.
  - State = IDLE.
  - cache_instruction_addr = RESET_PC.
- Icache contract: valid in a cycle means data matches the address driven in that same cycle. Address changes only after an accepted response, or on a jump.
- State machine:
  - IDLE: entered on reset. Moves to REQ on the first cycle with reset=1.
  - REQ: drive pc. On cache_instruction_valid, push {pc, data} and set pc += 4 (mod 2^XLEN). After the push, go to FULL if occupancy (including same-cycle pop) equals QUEUE_DEPTH; otherwise stay in REQ.
  - FULL: hold the address and ignore cache_instruction_valid. Return to REQ in the cycle after any pop.
- Throughput and latency:
  - With a zero-latency cache: 1 instruction/cycle.
  - First decode_instruction_valid appears 2 cycles after reset deasserts (address in cycle 1, registered push, visible in cycle 2).
- Queue:
  - Registered circular buffer; decode_instruction_data and decode_instruction_valid come straight from head and count.
  - Pop when valid && ready. Simultaneous push and pop keeps the count unchanged.
  - Never overflows: no push is accepted when the queue is full and no pop occurs.
- Jump (highest priority):
  - In the jump cycle, any cache response is discarded and the queue is flushed.
  - Next cycle: pc = {jump_addr[XLEN-1:2], 2'b00}, count = 0, decode_instruction_valid = 0, state = REQ.
  - A decode handshake completed in the jump cycle still counts as transferred.
  - jump while in FULL is handled the same way.
- Reset asserted mid-operation: applies the reset values at the next edge and overrides jump.
- PC wrap: from 2^XLEN-4 to 0, silently.

Optional Feature:
Macro FETCH_QUEUE_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles (32): counts cycles in REQ without cache_instruction_valid, plus cycles in FULL.
  - Adds output perf_flush_count (32): counts jump pulses.
  - Both saturate at 2^32-1 and reset to 0.
- Not defined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- riscv_isa package gains:
  - typedef FETCH_PACKET {logic [XLEN-1:0] pc; INSTRUCTION instr;}
  - enum FETCH_STATE {IDLE, REQ, FULL}
- Queue is a sub-module fetch_fifo (parametrised DEPTH, data type, synchronous flush, count output), reusable elsewhere.

Test Plan:
- Reset release, delay-0 icache, decode_ready=1 -> pc sequence 0x0, 0x4, 0x8 on decode_instruction_data from cycle 2; one instruction per cycle.
- decode_ready=0 with QUEUE_DEPTH=4 -> queue_count reaches 4 after 4 pushes, state FULL, address held at 0x10. Ready=1 for one cycle -> count=3, then refill to 4 with pc 0x10.
- Icache delay=3 -> one push every 4 cycles; decode_instruction_valid gaps match; no duplicate or skipped pc.
- jump=1, jump_addr=0x103 with queue holding 3 entries -> next cycle count=0, valid=0, cache_instruction_addr=0x100; first decode pc is 0x100.
- jump in the same cycle as cache_instruction_valid and a decode pop -> response discarded, popped entry counted once, no stale entry after the flush.
- reset=0 asserted mid-stream in FULL -> next cycle count=0, address=RESET_PC; with FETCH_QUEUE_PERF_EN defined, perf counters read 0.
